// File: rtl/bypass_lane_arbiter_if.sv
// Producer handshake and lane bus shared between the result producers and bypass_lane_arbiter.
`timescale 1ns/1ps
interface bypass_lane_arbiter_if #(
    parameter int NUM_REQ  = 6,
    parameter int NUM_LANE = 4,
    parameter int TAG_W    = 7,
    parameter int DATA_W   = 64,
    parameter int SRC_W    = 3
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*TAG_W-1:0]   req_tag;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_LANE-1:0]        lane_valid;
    logic [NUM_LANE*TAG_W-1:0]  lane_tag;
    logic [NUM_LANE*DATA_W-1:0] lane_data;
    logic [NUM_LANE*SRC_W-1:0]  lane_src;

    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready, lane_valid, lane_tag, lane_data, lane_src
    );

    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready, lane_valid, lane_tag, lane_data, lane_src
    );
endinterface

// File: rtl/bypass_lane_arbiter.sv
// Per-producer 2-entry result buffers drained onto NUM_LANE registered bypass lanes
// by a rotating-priority arbiter; flush squashes everything buffered.
`timescale 1ns/1ps
module bypass_lane_arbiter #(
    parameter int NUM_REQ   = 6,
    parameter int NUM_LANE  = 4,
    parameter int TAG_W     = 7,
    parameter int DATA_W    = 64,
    parameter int BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    bypass_lane_arbiter_if.slave bus
);
    localparam int SRC_W  = 3;
    localparam int CNT_W  = $clog2(NUM_LANE + 1);
    localparam int LANE_W = $clog2(NUM_LANE);

    logic [TAG_W-1:0]   buf_tag  [NUM_REQ][BUF_DEPTH];
    logic [DATA_W-1:0]  buf_data [NUM_REQ][BUF_DEPTH];
    logic [NUM_REQ-1:0] rd_ptr;
    logic [NUM_REQ-1:0] wr_ptr;
    logic [1:0]         count [NUM_REQ];
    logic [SRC_W-1:0]   ptr;

    logic [NUM_REQ-1:0]  ready;
    logic [NUM_REQ-1:0]  enq;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_LANE-1:0] lane_hit;
    logic [SRC_W-1:0]    lane_sel [NUM_LANE];
    logic [SRC_W-1:0]    ptr_next;
    logic                any_grant;

    logic [NUM_LANE-1:0] lane_valid_q;
    logic [TAG_W-1:0]    lane_tag_q  [NUM_LANE];
    logic [DATA_W-1:0]   lane_data_q [NUM_LANE];
    logic [SRC_W-1:0]    lane_src_q  [NUM_LANE];

    // Ready comes only from the registered count, so a full buffer stays closed even while draining.
    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            ready[r] = (count[r] < 2'd2);
            enq[r]   = bus.req_valid[r] & ready[r] & ~flush;
        end
    end

    always_comb begin
        logic [SRC_W:0]   idx;
        logic [CNT_W-1:0] n;
        idx       = '0;
        n         = '0;
        grant     = '0;
        lane_hit  = '0;
        any_grant = 1'b0;
        ptr_next  = ptr;
        for (int l = 0; l < NUM_LANE; l++) lane_sel[l] = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + (SRC_W+1)'(i);
            if (idx >= (SRC_W+1)'(NUM_REQ)) idx = idx - (SRC_W+1)'(NUM_REQ);
            if (!flush && count[idx[SRC_W-1:0]] != 2'd0 && n < CNT_W'(NUM_LANE)) begin
                grant[idx[SRC_W-1:0]]  = 1'b1;
                lane_hit[n[LANE_W-1:0]] = 1'b1;
                lane_sel[n[LANE_W-1:0]] = idx[SRC_W-1:0];
                ptr_next  = (idx[SRC_W-1:0] == SRC_W'(NUM_REQ - 1)) ? '0 : idx[SRC_W-1:0] + 1'b1;
                any_grant = 1'b1;
                n = n + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            ptr    <= '0;
            for (int r = 0; r < NUM_REQ; r++) count[r] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            ptr    <= '0;
            for (int r = 0; r < NUM_REQ; r++) count[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (enq[r])   wr_ptr[r] <= ~wr_ptr[r];
                if (grant[r]) rd_ptr[r] <= ~rd_ptr[r];
                if (enq[r] && !grant[r])      count[r] <= count[r] + 2'd1;
                else if (!enq[r] && grant[r]) count[r] <= count[r] - 2'd1;
            end
            if (any_grant) ptr <= ptr_next;
        end
    end

    // Storage needs no reset: count alone decides which entries are live.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REQ; r++) begin
            if (enq[r]) begin
                buf_tag[r][wr_ptr[r]]  <= bus.req_tag[r*TAG_W +: TAG_W];
                buf_data[r][wr_ptr[r]] <= bus.req_data[r*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_valid_q <= '0;
            for (int l = 0; l < NUM_LANE; l++) begin
                lane_tag_q[l]  <= '0;
                lane_data_q[l] <= '0;
                lane_src_q[l]  <= '0;
            end
        end else begin
            lane_valid_q <= lane_hit;
            for (int l = 0; l < NUM_LANE; l++) begin
                if (lane_hit[l]) begin
                    lane_src_q[l]  <= lane_sel[l];
                    lane_tag_q[l]  <= buf_tag[lane_sel[l]][rd_ptr[lane_sel[l]]];
                    lane_data_q[l] <= buf_data[lane_sel[l]][rd_ptr[lane_sel[l]]];
                end
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.lane_valid = lane_valid_q;

    for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
        assign bus.lane_tag[l*TAG_W +: TAG_W]    = lane_tag_q[l];
        assign bus.lane_data[l*DATA_W +: DATA_W] = lane_data_q[l];
        assign bus.lane_src[l*SRC_W +: SRC_W]    = lane_src_q[l];
    end
endmodule

// File: tb/tb_bypass_lane_arbiter.sv
// Directed self-checking bench for bypass_lane_arbiter: one task per scenario,
// with a per-producer FIFO scoreboard for the streaming scenarios.
`timescale 1ns/1ps
module tb_bypass_lane_arbiter;
    localparam int NUM_REQ  = 6;
    localparam int NUM_LANE = 4;
    localparam int TAG_W    = 7;
    localparam int DATA_W   = 64;
    localparam int SRC_W    = 3;
    localparam int SB_DEPTH = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int tests_run    = 0;
    int tests_failed = 0;

    logic [TAG_W+DATA_W-1:0] sb_mem [NUM_REQ][SB_DEPTH];
    int sb_head [NUM_REQ];
    int sb_tail [NUM_REQ];
    int seq     [NUM_REQ];

    bypass_lane_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_LANE(NUM_LANE), .TAG_W(TAG_W),
                             .DATA_W(DATA_W), .SRC_W(SRC_W)) bus ();

    bypass_lane_arbiter #(.NUM_REQ(NUM_REQ), .NUM_LANE(NUM_LANE), .TAG_W(TAG_W),
                          .DATA_W(DATA_W), .BUF_DEPTH(2)) dut (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TAG_W-1:0] get_tag(int l);
        return bus.lane_tag[l*TAG_W +: TAG_W];
    endfunction

    function automatic logic [DATA_W-1:0] get_data(int l);
        return bus.lane_data[l*DATA_W +: DATA_W];
    endfunction

    function automatic int get_src(int l);
        return int'(bus.lane_src[l*SRC_W +: SRC_W]);
    endfunction

    task automatic push(int r, logic [TAG_W-1:0] t, logic [DATA_W-1:0] d);
        bus.req_valid[r] = 1'b1;
        bus.req_tag[r*TAG_W +: TAG_W]    = t;
        bus.req_data[r*DATA_W +: DATA_W] = d;
    endtask

    task automatic idle_all();
        bus.req_valid = '0;
    endtask

    task automatic sb_clear();
        for (int r = 0; r < NUM_REQ; r++) begin
            sb_head[r] = 0;
            sb_tail[r] = 0;
            seq[r]     = 0;
        end
    endtask

    // Producer side of the handshake: remember what the arbiter accepts this cycle.
    task automatic sb_record();
        for (int r = 0; r < NUM_REQ; r++) begin
            if (bus.req_valid[r] && bus.req_ready[r] && !flush) begin
                sb_mem[r][sb_tail[r] % SB_DEPTH] = {bus.req_tag[r*TAG_W +: TAG_W],
                                                    bus.req_data[r*DATA_W +: DATA_W]};
                sb_tail[r]++;
                seq[r]++;
            end
        end
    endtask

    function automatic logic [TAG_W-1:0] stream_tag(int r);
        return TAG_W'(r * 16 + (seq[r] % 16));
    endfunction

    function automatic logic [DATA_W-1:0] stream_data(int r);
        return {32'(r), 32'(seq[r]) ^ 32'hA5A5_0000};
    endfunction

    task automatic test_reset();
        bus.req_valid = '0;
        bus.req_tag   = '0;
        bus.req_data  = '0;
        flush = 1'b0;
        #2 reset = 1'b0;
        #1;
        tests_run++; if (bus.lane_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_lane_valid: got %b expected %b", bus.lane_valid, 4'b0000); end
        tests_run++; if (bus.lane_tag !== '0) begin tests_failed++; $display("[TB] FAIL reset_lane_tag: got %h expected 0", bus.lane_tag); end
        tests_run++; if (bus.lane_data !== '0) begin tests_failed++; $display("[TB] FAIL reset_lane_data: got %h expected 0", bus.lane_data); end
        tests_run++; if (bus.lane_src !== '0) begin tests_failed++; $display("[TB] FAIL reset_lane_src: got %h expected 0", bus.lane_src); end
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        tick();
        tests_run++; if (bus.req_ready !== 6'h3F) begin tests_failed++; $display("[TB] FAIL reset_ready: got %h expected %h", bus.req_ready, 6'h3F); end
        tests_run++; if (bus.lane_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_idle_valid: got %b expected %b", bus.lane_valid, 4'b0000); end
    endtask

    task automatic test_oversubscription();
        int exp_src [NUM_LANE];
        for (int r = 0; r < NUM_REQ; r++) push(r, TAG_W'(8'h10 + r), DATA_W'(64'h1000 + r));
        tick();
        idle_all();
        tests_run++; if (bus.lane_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL over_c1_valid: got %b expected %b", bus.lane_valid, 4'b0000); end
        tick();
        tests_run++; if (bus.lane_valid !== 4'b1111) begin tests_failed++; $display("[TB] FAIL over_c2_valid: got %b expected %b", bus.lane_valid, 4'b1111); end
        for (int l = 0; l < NUM_LANE; l++) begin
            tests_run++; if (get_src(l) !== l) begin tests_failed++; $display("[TB] FAIL over_c2_src%0d: got %0d expected %0d", l, get_src(l), l); end
            tests_run++; if (get_tag(l) !== TAG_W'(8'h10 + l)) begin tests_failed++; $display("[TB] FAIL over_c2_tag%0d: got %h expected %h", l, get_tag(l), 8'h10 + l); end
        end
        tests_run++; if (get_data(3) !== 64'h1003) begin tests_failed++; $display("[TB] FAIL over_c2_data3: got %h expected %h", get_data(3), 64'h1003); end
        tick();
        exp_src = '{4, 5, 2, 3};
        tests_run++; if (bus.lane_valid !== 4'b0011) begin tests_failed++; $display("[TB] FAIL over_c3_valid: got %b expected %b", bus.lane_valid, 4'b0011); end
        for (int l = 0; l < NUM_LANE; l++) begin
            tests_run++; if (get_src(l) !== exp_src[l]) begin tests_failed++; $display("[TB] FAIL over_c3_src%0d: got %0d expected %0d", l, get_src(l), exp_src[l]); end
        end
        tests_run++; if (get_tag(1) !== 7'h15) begin tests_failed++; $display("[TB] FAIL over_c3_tag1: got %h expected %h", get_tag(1), 7'h15); end
        tick();
        tests_run++; if (bus.lane_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL over_c4_valid: got %b expected %b", bus.lane_valid, 4'b0000); end
        // Pointer should have wrapped to 0: producer 0 must win lane 0 over producer 5.
        push(0, 7'h30, 64'h30);
        push(5, 7'h35, 64'h35);
        tick();
        idle_all();
        tick();
        tests_run++; if (bus.lane_valid !== 4'b0011) begin tests_failed++; $display("[TB] FAIL over_ptr_valid: got %b expected %b", bus.lane_valid, 4'b0011); end
        tests_run++; if (get_src(0) !== 0) begin tests_failed++; $display("[TB] FAIL over_ptr_src0: got %0d expected 0", get_src(0)); end
        tests_run++; if (get_src(1) !== 5) begin tests_failed++; $display("[TB] FAIL over_ptr_src1: got %0d expected 5", get_src(1)); end
        tick();
    endtask

    task automatic test_single_result();
        int exp_src [NUM_LANE];
        push(2, 7'h15, 64'hDEAD);
        tick();
        idle_all();
        tests_run++; if (bus.lane_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL single_c1_valid: got %b expected %b", bus.lane_valid, 4'b0000); end
        tick();
        tests_run++; if (bus.lane_valid !== 4'b0001) begin tests_failed++; $display("[TB] FAIL single_valid: got %b expected %b", bus.lane_valid, 4'b0001); end
        tests_run++; if (get_tag(0) !== 7'h15) begin tests_failed++; $display("[TB] FAIL single_tag: got %h expected %h", get_tag(0), 7'h15); end
        tests_run++; if (get_data(0) !== 64'hDEAD) begin tests_failed++; $display("[TB] FAIL single_data: got %h expected %h", get_data(0), 64'hDEAD); end
        tests_run++; if (get_src(0) !== 2) begin tests_failed++; $display("[TB] FAIL single_src: got %0d expected 2", get_src(0)); end
        tick();
        tests_run++; if (bus.lane_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL single_after_valid: got %b expected %b", bus.lane_valid, 4'b0000); end
        // Pointer is now 3, so a full burst starts scanning at producer 3.
        for (int r = 0; r < NUM_REQ; r++) push(r, TAG_W'(8'h20 + r), DATA_W'(64'h2000 + r));
        tick();
        idle_all();
        tick();
        exp_src = '{3, 4, 5, 0};
        tests_run++; if (bus.lane_valid !== 4'b1111) begin tests_failed++; $display("[TB] FAIL single_ptr_valid: got %b expected %b", bus.lane_valid, 4'b1111); end
        for (int l = 0; l < NUM_LANE; l++) begin
            tests_run++; if (get_src(l) !== exp_src[l]) begin tests_failed++; $display("[TB] FAIL single_ptr_src%0d: got %0d expected %0d", l, get_src(l), exp_src[l]); end
        end
        tick();
        exp_src = '{1, 2, 5, 0};
        tests_run++; if (bus.lane_valid !== 4'b0011) begin tests_failed++; $display("[TB] FAIL single_ptr2_valid: got %b expected %b", bus.lane_valid, 4'b0011); end
        for (int l = 0; l < NUM_LANE; l++) begin
            tests_run++; if (get_src(l) !== exp_src[l]) begin tests_failed++; $display("[TB] FAIL single_ptr2_src%0d: got %0d expected %0d", l, get_src(l), exp_src[l]); end
        end
        tests_run++; if (get_tag(3) !== 7'h20) begin tests_failed++; $display("[TB] FAIL single_hold_tag3: got %h expected %h", get_tag(3), 7'h20); end
        tick();
    endtask

    task automatic test_rotation();
        localparam int N = 10;
        int s;
        int exp0;
        logic [TAG_W+DATA_W-1:0] exp;
        sb_clear();
        for (int k = 0; k < N + 8; k++) begin
            for (int l = 0; l < NUM_LANE; l++) begin
                if (bus.lane_valid[l]) begin
                    s = get_src(l);
                    tests_run++;
                    if (s >= NUM_REQ || sb_head[s] == sb_tail[s]) begin
                        tests_failed++; $display("[TB] FAIL rot_extra: lane %0d src %0d got an entry expected none", l, s);
                    end else begin
                        exp = sb_mem[s][sb_head[s] % SB_DEPTH];
                        sb_head[s]++;
                        if ({get_tag(l), get_data(l)} !== exp) begin
                            tests_failed++; $display("[TB] FAIL rot_order: lane %0d src %0d got %h expected %h", l, s, {get_tag(l), get_data(l)}, exp);
                        end
                    end
                end
            end
            if (k >= 2 && k <= N + 1) begin
                exp0 = (3 + 4 * (k - 2)) % NUM_REQ;
                tests_run++; if (bus.lane_valid !== 4'b1111) begin tests_failed++; $display("[TB] FAIL rot_full k=%0d: got %b expected %b", k, bus.lane_valid, 4'b1111); end
                for (int l = 0; l < NUM_LANE; l++) begin
                    tests_run++; if (get_src(l) !== (exp0 + l) % NUM_REQ) begin tests_failed++; $display("[TB] FAIL rot_src k=%0d lane %0d: got %0d expected %0d", k, l, get_src(l), (exp0 + l) % NUM_REQ); end
                end
            end
            idle_all();
            if (k < N) for (int r = 0; r < NUM_REQ; r++) push(r, stream_tag(r), stream_data(r));
            sb_record();
            tick();
        end
        idle_all();
        for (int r = 0; r < NUM_REQ; r++) begin
            tests_run++; if (sb_head[r] != sb_tail[r]) begin tests_failed++; $display("[TB] FAIL rot_lost p%0d: got %0d delivered expected %0d", r, sb_head[r], sb_tail[r]); end
        end
    endtask

    task automatic test_back_pressure();
        int s;
        int stalls;
        logic [TAG_W+DATA_W-1:0] exp;
        int exp_src [NUM_LANE];
        flush = 1'b1;
        idle_all();
        tick();
        flush = 1'b0;
        sb_clear();
        stalls = 0;
        for (int k = 0; k < 14; k++) begin
            for (int l = 0; l < NUM_LANE; l++) begin
                if (bus.lane_valid[l]) begin
                    s = get_src(l);
                    tests_run++;
                    if (s >= NUM_REQ || sb_head[s] == sb_tail[s]) begin
                        tests_failed++; $display("[TB] FAIL bp_extra: lane %0d src %0d got an entry expected none", l, s);
                    end else begin
                        exp = sb_mem[s][sb_head[s] % SB_DEPTH];
                        sb_head[s]++;
                        if ({get_tag(l), get_data(l)} !== exp) begin
                            tests_failed++; $display("[TB] FAIL bp_order: lane %0d src %0d got %h expected %h", l, s, {get_tag(l), get_data(l)}, exp);
                        end
                    end
                end
            end
            if (k == 2) begin
                tests_run++; if (bus.lane_valid !== 4'b0001 || get_src(0) !== 0) begin tests_failed++; $display("[TB] FAIL bp_k2_lanes: got valid %b src %0d expected valid 0001 src 0", bus.lane_valid, get_src(0)); end
                tests_run++; if (bus.req_ready[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_k2_ready0: got %b expected 1", bus.req_ready[0]); end
            end
            if (k == 3 || k == 4) begin
                exp_src = (k == 3) ? '{1, 2, 3, 4} : '{5, 0, 1, 2};
                tests_run++; if (bus.req_ready[0] !== (k == 4)) begin tests_failed++; $display("[TB] FAIL bp_k%0d_ready0: got %b expected %b", k, bus.req_ready[0], (k == 4)); end
                tests_run++; if (bus.lane_valid !== 4'b1111) begin tests_failed++; $display("[TB] FAIL bp_k%0d_valid: got %b expected %b", k, bus.lane_valid, 4'b1111); end
                for (int l = 0; l < NUM_LANE; l++) begin
                    tests_run++; if (get_src(l) !== exp_src[l]) begin tests_failed++; $display("[TB] FAIL bp_k%0d_src%0d: got %0d expected %0d", k, l, get_src(l), exp_src[l]); end
                end
            end
            idle_all();
            if (seq[0] < 4 && k < 8) push(0, stream_tag(0), stream_data(0));
            if (k >= 1 && k <= 6) for (int r = 1; r < NUM_REQ; r++) push(r, stream_tag(r), stream_data(r));
            if (bus.req_valid[0] && !bus.req_ready[0]) stalls++;
            sb_record();
            tick();
        end
        idle_all();
        tests_run++; if (stalls != 1) begin tests_failed++; $display("[TB] FAIL bp_stalls0: got %0d expected 1", stalls); end
        for (int r = 0; r < NUM_REQ; r++) begin
            tests_run++; if (sb_head[r] != sb_tail[r]) begin tests_failed++; $display("[TB] FAIL bp_lost p%0d: got %0d delivered expected %0d", r, sb_head[r], sb_tail[r]); end
        end
    endtask

    task automatic test_flush();
        push(2, 7'h02, 64'h2);
        tick();
        idle_all();
        tick();
        tick();
        tick();
        for (int r = 0; r < NUM_REQ; r++) push(r, TAG_W'(8'h40 + r), DATA_W'(64'h4000 + r));
        tick();
        idle_all();
        flush = 1'b1;
        push(0, 7'h50, 64'h5000);
        push(1, 7'h51, 64'h5001);
        tests_run++; if (bus.lane_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL flush_n_valid: got %b expected %b", bus.lane_valid, 4'b0000); end
        tick();
        flush = 1'b0;
        idle_all();
        tests_run++; if (bus.lane_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL flush_n1_valid: got %b expected %b", bus.lane_valid, 4'b0000); end
        tests_run++; if (bus.req_ready !== 6'h3F) begin tests_failed++; $display("[TB] FAIL flush_ready: got %h expected %h", bus.req_ready, 6'h3F); end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++; if (bus.lane_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL flush_leak k=%0d: got %b expected %b", k, bus.lane_valid, 4'b0000); end
        end
        push(0, 7'h30, 64'h30);
        push(5, 7'h35, 64'h35);
        tick();
        idle_all();
        tick();
        tests_run++; if (get_src(0) !== 0 || get_src(1) !== 5 || bus.lane_valid !== 4'b0011) begin tests_failed++; $display("[TB] FAIL flush_ptr: got valid %b src0 %0d src1 %0d expected 0011 0 5", bus.lane_valid, get_src(0), get_src(1)); end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < NUM_REQ; r++) push(r, TAG_W'(8'h60 + r), DATA_W'(64'h6000 + r));
        tick();
        idle_all();
        tick();
        tests_run++; if (bus.lane_valid !== 4'b1111) begin tests_failed++; $display("[TB] FAIL rmid_pre_valid: got %b expected %b", bus.lane_valid, 4'b1111); end
        #3 reset = 1'b0;
        #1;
        tests_run++; if (bus.lane_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL rmid_valid: got %b expected %b", bus.lane_valid, 4'b0000); end
        tests_run++; if (bus.lane_tag !== '0 || bus.lane_src !== '0 || bus.lane_data !== '0) begin tests_failed++; $display("[TB] FAIL rmid_fields: got tag %h src %h expected 0", bus.lane_tag, bus.lane_src); end
        @(posedge clk);
        #3 reset = 1'b1;
        tick();
        tests_run++; if (bus.req_ready !== 6'h3F) begin tests_failed++; $display("[TB] FAIL rmid_ready: got %h expected %h", bus.req_ready, 6'h3F); end
        for (int k = 0; k < 3; k++) begin
            tests_run++; if (bus.lane_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL rmid_leak k=%0d: got %b expected %b", k, bus.lane_valid, 4'b0000); end
            tick();
        end
        push(3, 7'h73, 64'hBEEF);
        tick();
        idle_all();
        tests_run++; if (bus.lane_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL rmid_c1_valid: got %b expected %b", bus.lane_valid, 4'b0000); end
        tick();
        tests_run++; if (bus.lane_valid !== 4'b0001) begin tests_failed++; $display("[TB] FAIL rmid_c2_valid: got %b expected %b", bus.lane_valid, 4'b0001); end
        tests_run++; if (get_src(0) !== 3 || get_tag(0) !== 7'h73 || get_data(0) !== 64'hBEEF) begin tests_failed++; $display("[TB] FAIL rmid_c2_lane0: got src %0d tag %h data %h expected 3 73 beef", get_src(0), get_tag(0), get_data(0)); end
    endtask

    initial begin
        test_reset();
        test_oversubscription();
        test_single_result();
        test_rotation();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
